// File: rtl/matrix_ram_stream_reader.sv
// rtl/matrix_ram_stream_reader.sv - matrix BRAM read sequencer presenting words as a valid/ready stream
//
// Purpose: on a start command, issues num_words sequential reads from base_addr
//          into a single-port matrix BRAM. It absorbs the RAM read latency in a small
//          skid FIFO and streams the words out with a last marker.
// Ports:
//   clka       clock, all logic on posedge
//   rsta       asynchronous active-high reset
//   start      command pulse, sampled only in IDLE
//   base_addr  first RAM address, sampled with start
//   num_words  word count, sampled with start, clamped to RAM_DEPTH
//   ram_addr   RAM address (addra)
//   ram_en     RAM enable (ena)
//   ram_regce  RAM output-register enable (regcea)
//   ram_dout   RAM read data (douta)
//   m_data     stream data
//   m_valid    stream valid
//   m_last     final word of the command
//   m_ready    stream ready from consumer
//   busy       command in progress
//   done       one-cycle pulse after the final handshake
module matrix_ram_stream_reader #(
   parameter int RAM_WIDTH    = 64,
   parameter int RAM_DEPTH    = 64,
   parameter int READ_LATENCY = 1,
   parameter int AW           = $clog2(RAM_DEPTH),
   parameter int CW           = $clog2(RAM_DEPTH + 1)
) (
   input  logic                 clka,
   input  logic                 rsta,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [CW-1:0]        num_words,
   output logic [AW-1:0]        ram_addr,
   output logic                 ram_en,
   output logic                 ram_regce,
   input  logic [RAM_WIDTH-1:0] ram_dout,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int D    = READ_LATENCY + 1;   // skid FIFO depth = max reads in flight
   localparam int PTRW = $clog2(D);
   localparam int CNW  = $clog2(D + 1);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE)");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [AW-1:0]           addr_q;
   logic [CW-1:0]           left_q;          // reads still to be issued
   logic [CW-1:0]           num_clamped;
   logic [CNW-1:0]          credit_q;        // issued but not yet popped
   logic [READ_LATENCY-1:0] pipe_vld_q;
   logic [READ_LATENCY-1:0] pipe_last_q;
   logic [RAM_WIDTH-1:0]    fifo_data_q [D];
   logic [D-1:0]            fifo_last_q;
   logic [PTRW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNW-1:0]          count_q;
   logic                    push, pop;

   function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
      return (p == PTRW'(D - 1)) ? '0 : p + PTRW'(1);
   endfunction

   assign num_clamped = (num_words > CW'(RAM_DEPTH)) ? CW'(RAM_DEPTH) : num_words;

   assign m_valid  = (count_q != '0);
   assign m_data   = fifo_data_q[rd_ptr_q];
   assign m_last   = fifo_last_q[rd_ptr_q];
   assign pop      = m_valid && m_ready;
   assign push     = pipe_vld_q[READ_LATENCY-1];
   assign ram_addr = addr_q;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (num_clamped == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (ram_en && left_q == CW'(1)) state_nxt = S_DRAIN;
         S_DRAIN: if (pop && m_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ram_en = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state)
         S_ISSUE: begin
            busy = 1'b1;
            // A full credit window may still issue when a slot frees this cycle.
            ram_en = (credit_q < CNW'(D)) || (credit_q == CNW'(D) && pop);
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         ram_regce <= 1'b0;
      end else begin
         ram_regce <= 1'b1;
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         addr_q <= '0;
         left_q <= '0;
      end else if (state == S_IDLE && start) begin
         addr_q <= base_addr;
         left_q <= num_clamped;
      end else if (ram_en) begin
         addr_q <= (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
         left_q <= left_q - CW'(1);
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         credit_q <= '0;
      end else begin
         credit_q <= credit_q + CNW'(ram_en) - CNW'(pop);
      end
   end

   // Tracks each read through the RAM pipeline so its data is captured exactly
   // READ_LATENCY cycles after the enable, along with its last flag.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
      end else begin
         pipe_vld_q[0]  <= ram_en;
         pipe_last_q[0] <= ram_en && (left_q == CW'(1));
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
         end
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fifo_last_q <= '0;
         for (int i = 0; i < D; i++) fifo_data_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q] <= ram_dout;
            fifo_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
            wr_ptr_q              <= ptr_next(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
         count_q <= count_q + CNW'(push) - CNW'(pop);
      end
   end

endmodule

// File: tb/tb_matrix_ram_stream_reader.sv
// tb/tb_matrix_ram_stream_reader.sv - self-checking bench for matrix_ram_stream_reader at both read latencies
module tb_matrix_ram_stream_reader;

   localparam int W   = 64;
   localparam int DEP = 64;
   localparam int AW  = 6;
   localparam int CW  = 7;
   localparam logic [W-1:0] STEP = 64'h0101_0101_0101_0101;

   logic clka = 1'b0;
   always #5 clka = ~clka;

   logic          rsta, start, m_ready;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] num_words;

   logic [AW-1:0] ram_addr_1, ram_addr_2;
   logic          ram_en_1, ram_en_2, ram_regce_1, ram_regce_2;
   logic [W-1:0]  ram_dout_1, ram_dout_2, m_data_1, m_data_2;
   logic          m_valid_1, m_valid_2, m_last_1, m_last_2;
   logic          busy_1, busy_2, done_1, done_2;

   matrix_ram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEP), .READ_LATENCY(1)) u_dut_l1 (
      .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .num_words(num_words),
      .ram_addr(ram_addr_1), .ram_en(ram_en_1), .ram_regce(ram_regce_1), .ram_dout(ram_dout_1),
      .m_data(m_data_1), .m_valid(m_valid_1), .m_last(m_last_1), .m_ready(m_ready),
      .busy(busy_1), .done(done_1));

   matrix_ram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEP), .READ_LATENCY(2)) u_dut_l2 (
      .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .num_words(num_words),
      .ram_addr(ram_addr_2), .ram_en(ram_en_2), .ram_regce(ram_regce_2), .ram_dout(ram_dout_2),
      .m_data(m_data_2), .m_valid(m_valid_2), .m_last(m_last_2), .m_ready(m_ready),
      .busy(busy_2), .done(done_2));

   // RAM models: mem[i] = i * 0x0101..01
   logic [W-1:0] mem [DEP];
   logic [W-1:0] rd1_q = '0, rd2_a = '0, rd2_b = '0;
   initial for (int i = 0; i < DEP; i++) mem[i] = STEP * 64'(i);
   always @(posedge clka) if (ram_en_1) rd1_q <= mem[ram_addr_1];
   always @(posedge clka) begin
      if (ram_en_2) rd2_a <= mem[ram_addr_2];
      if (ram_regce_2) rd2_b <= rd2_a;
   end
   assign ram_dout_1 = rd1_q;
   assign ram_dout_2 = rd2_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int duty     = 100;
   always @(posedge clka) cyc <= cyc + 1;

   // Behavioural model: expected {last,word} and address sequences per instance.
   logic [W:0]    exp_q0[$], exp_q1[$];
   logic [AW-1:0] adr_q0[$], adr_q1[$];
   int            outst[2], done_cyc[2], cmd_cyc[2], hs_n[2];
   bit            busy_m[2], cmd_nz[2], first_seen[2], stall_p[2];
   logic [W:0]    prev_w[2];
   int            hs_rel[2][64];
   logic [W:0]    hs_w[2][64];

   task automatic chk_i(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_w(input string name, input logic [W:0] act, input logic [W:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic clear_model();
      exp_q0.delete(); exp_q1.delete(); adr_q0.delete(); adr_q1.delete();
      for (int k = 0; k < 2; k++) begin
         outst[k] = 0; done_cyc[k] = -10; cmd_cyc[k] = -10; hs_n[k] = 0;
         busy_m[k] = 0; cmd_nz[k] = 0; first_seen[k] = 1; stall_p[k] = 0; prev_w[k] = '0;
      end
   endtask

   task automatic check_inst(input int k, input logic en, input logic [AW-1:0] adr, input logic vld,
                             input logic [W:0] w, input logic bsy, input logic dn);
      logic [W:0]    e;
      logic [AW-1:0] ea;
      int            lat;
      int            sz_a, sz_e;
      lat  = k + 1;
      sz_a = (k == 0) ? adr_q0.size() : adr_q1.size();
      sz_e = (k == 0) ? exp_q0.size() : exp_q1.size();
      chk_i($sformatf("busy_l%0d", lat), int'(bsy), int'(busy_m[k]));
      chk_i($sformatf("done_l%0d", lat), int'(dn), int'(cyc == done_cyc[k]));
      if (stall_p[k]) begin
         chk_i($sformatf("stall_valid_l%0d", lat), int'(vld), 1);
         chk_w($sformatf("stall_word_l%0d", lat), w, prev_w[k]);
      end
      if (vld && !first_seen[k] && cmd_nz[k]) begin
         first_seen[k] = 1;
         chk_i($sformatf("first_valid_latency_l%0d", lat), cyc - cmd_cyc[k], lat + 2);
      end
      if (en) begin
         if (sz_a == 0) chk_i($sformatf("ram_en_unexpected_l%0d", lat), 1, 0);
         else begin
            ea = (k == 0) ? adr_q0.pop_front() : adr_q1.pop_front();
            chk_i($sformatf("ram_addr_l%0d", lat), int'(adr), int'(ea));
         end
      end
      if (vld && m_ready) begin
         if (sz_e == 0) chk_i($sformatf("word_unexpected_l%0d", lat), 1, 0);
         else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk_w($sformatf("word_l%0d", lat), w, e);
            if (hs_n[k] < 64) begin
               hs_rel[k][hs_n[k]] = cyc - cmd_cyc[k];
               hs_w[k][hs_n[k]]   = w;
            end
            hs_n[k]++;
            if (e[W]) begin
               done_cyc[k] = cyc + 1;
               busy_m[k]   = 0;
            end
         end
      end
      outst[k] = outst[k] + int'(en) - int'(vld && m_ready);
      if (en) chk_i($sformatf("credit_bound_l%0d", lat), int'(outst[k] <= lat + 1), 1);
      stall_p[k] = vld && !m_ready;
      prev_w[k]  = w;
      if (cyc == cmd_cyc[k] && cmd_nz[k]) busy_m[k] = 1;
   endtask

   always @(negedge clka) begin
      if (!rsta) begin
         check_inst(0, ram_en_1, ram_addr_1, m_valid_1, {m_last_1, m_data_1}, busy_1, done_1);
         check_inst(1, ram_en_2, ram_addr_2, m_valid_2, {m_last_2, m_data_2}, busy_2, done_2);
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clka); #1;
         m_ready = ($urandom_range(0, 99) < duty);
      end
   end

   task automatic check_zero_outputs(input string tag);
      chk_i({tag, "_ram_en"},  int'(ram_en_1)  + int'(ram_en_2), 0);
      chk_i({tag, "_ram_addr"}, int'(ram_addr_1) + int'(ram_addr_2), 0);
      chk_i({tag, "_m_valid"}, int'(m_valid_1) + int'(m_valid_2), 0);
      chk_i({tag, "_m_last"},  int'(m_last_1)  + int'(m_last_2), 0);
      chk_w({tag, "_m_data"},  {1'b0, m_data_1 | m_data_2}, '0);
      chk_i({tag, "_busy"},    int'(busy_1)    + int'(busy_2), 0);
      chk_i({tag, "_done"},    int'(done_1)    + int'(done_2), 0);
   endtask

   task automatic do_reset(input string tag);
      rsta = 1'b1;
      #1;
      check_zero_outputs(tag);
      clear_model();
      start = 1'b0;
      @(posedge clka); @(posedge clka); #1;
      rsta = 1'b0;
      @(posedge clka); #1;
      chk_i({tag, "_regce_after_release"}, int'(ram_regce_1) + int'(ram_regce_2), 2);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_1 || busy_2 || done_1 || done_2 || m_valid_1 || m_valid_2 ||
             exp_q0.size() != 0 || exp_q1.size() != 0) begin
         @(posedge clka); #1;
         n++;
         if (n > 3000) begin
            chk_i("idle_timeout", n, 0);
            do_reset("recover");
            break;
         end
      end
   endtask

   task automatic issue(input int base, input int num);
      int n, a;
      wait_idle();
      n = (num > DEP) ? DEP : num;
      start     = 1'b1;
      base_addr = AW'(base);
      num_words = CW'(num);
      for (int k = 0; k < 2; k++) begin
         cmd_cyc[k] = cyc; cmd_nz[k] = (n != 0); first_seen[k] = 0; hs_n[k] = 0;
         if (n == 0) done_cyc[k] = cyc + 1;
      end
      for (int i = 0; i < n; i++) begin
         a = (base + i) % DEP;
         exp_q0.push_back({i == n - 1, mem[a]}); exp_q1.push_back({i == n - 1, mem[a]});
         adr_q0.push_back(AW'(a));               adr_q1.push_back(AW'(a));
      end
      @(posedge clka); #1;
      start = 1'b0;
   endtask

   initial begin
      int n;
      rsta = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
      clear_model();
      do_reset("reset");

      // 1) base 0, 4 words, full throughput
      duty = 100;
      issue(0, 4);
      wait_idle();
      chk_i("t1_count_l1", hs_n[0], 4);
      chk_i("t1_count_l2", hs_n[1], 4);
      for (int i = 0; i < 4; i++) begin
         chk_i("t1_cycle_l1", hs_rel[0][i], 3 + i);
         chk_i("t1_cycle_l2", hs_rel[1][i], 4 + i);
         chk_w("t1_word_l1", hs_w[0][i], {i == 3, STEP * 64'(i)});
      end

      // 2) wrap from 62
      issue(62, 4);
      wait_idle();
      chk_i("t2_first_valid_l2", hs_rel[1][0], 4);
      chk_w("t2_w0", hs_w[1][0], {1'b0, 64'h3E3E_3E3E_3E3E_3E3E});
      chk_w("t2_w1", hs_w[1][1], {1'b0, 64'h3F3F_3F3F_3F3F_3F3F});
      chk_w("t2_w2", hs_w[1][2], {1'b0, 64'h0000_0000_0000_0000});
      chk_w("t2_w3", hs_w[1][3], {1'b1, 64'h0101_0101_0101_0101});

      // 3) 16 words under 30% ready
      duty = 30;
      issue(7, 16);
      wait_idle();
      chk_i("t3_count_l1", hs_n[0], 16);
      chk_i("t3_count_l2", hs_n[1], 16);

      // 4) zero-length command
      duty = 100;
      issue(9, 0);
      wait_idle();
      chk_i("t4_count", hs_n[0] + hs_n[1], 0);

      // 5) clamp to 64 and ignore a start while busy
      duty = 70;
      issue(20, 100);
      repeat (3) @(posedge clka);
      #1;
      chk_i("t5_busy_before_restart", int'(busy_1 && busy_2), 1);
      start = 1'b1; base_addr = AW'(3); num_words = CW'(5);
      @(posedge clka); #1;
      start = 1'b0;
      wait_idle();
      chk_i("t5_count_l1", hs_n[0], 64);
      chk_i("t5_count_l2", hs_n[1], 64);

      // 6) reset after 5 of 10 words, then a fresh command
      duty = 100;
      issue(40, 10);
      n = 0;
      while (hs_n[0] < 5) begin
         @(posedge clka); #2;
         n++;
         if (n > 200) begin
            chk_i("t6_wait_timeout", n, 0);
            break;
         end
      end
      do_reset("t6_midreset");
      issue(10, 3);
      wait_idle();
      chk_i("t6_count", hs_n[0], 3);
      chk_w("t6_w0", hs_w[0][0], {1'b0, 64'h0A0A_0A0A_0A0A_0A0A});
      chk_w("t6_w2", hs_w[0][2], {1'b1, 64'h0C0C_0C0C_0C0C_0C0C});

      // randomized commands
      for (int t = 0; t < 12; t++) begin
         case ($urandom_range(0, 2))
            0:       duty = 30;
            1:       duty = 60;
            default: duty = 100;
         endcase
         issue(int'($urandom_range(0, DEP - 1)), int'($urandom_range(0, 80)));
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
